clk_div_gf: RTL
===============

// Module: clk_div_gf
// PURPOSE
//  Runtime-programmable integer clock divider. Ratio changes are applied only at
//  period boundaries, so o_div_clk never has a runt pulse. Odd ratios can run at
//  exact 50% duty. Also provides a period tick and a ratio-ack handshake.
//  Sits in the clock/reset block and feeds peripheral clocks (UART, SPI).
// PARAMETERS
//  DIV_WIDTH   8  width of the ratio and the counter; maximum ratio 2^DIV_WIDTH-1
//  DUTY50_ODD  1  1: odd ratios give exact 50% duty (negedge stage); 0: high = ceil(N/2) cycles
// PORTS
//  i_ref_clk      in   1          reference clock
//  i_rst          in   1          asynchronous, active-low reset
//  i_clk_en       in   1          divider enable (i_ref_clk domain)
//  i_div_ratio    in   DIV_WIDTH  requested ratio N
//  i_ratio_load   in   1          1-cycle strobe; capture i_div_ratio into pending
//  o_div_clk      out  1          divided clock, or i_ref_clk when bypassed
//  o_ratio_ack    out  1          1-cycle pulse: pending ratio became active
//  o_period_tick  out  1          1-cycle pulse on the first ref cycle of each divided period
//  o_bypass       out  1          1 while o_div_clk follows i_ref_clk
// BEHAVIOUR
//  Reset values: r_act=0, pend_vld=0, cnt=0, state=BYP, sel_q=0, pos_q=0, neg_q=0.
//   o_ratio_ack=0, o_period_tick=0, o_bypass=1, o_div_clk=i_ref_clk.
//  Registers:
//   - en_q: i_clk_en registered once.
//   - Pending: i_ratio_load writes pend_ratio and sets pend_vld. A later load overwrites it;
//     only one ack is issued.
//   - Valid ratio: N>=2. N=0 and N=1 force bypass.
//  States:
//   - BYP: cnt=0, pos_q=0. Any pend_vld is applied immediately (r_act<=pend, ack).
//     Go to ARM when en_q && r_act>=2.
//   - ARM (1 cycle): pos_q=0. Next state RUN, cnt=0.
//   - RUN: cnt counts 0..N-1 and wraps. pos_q=1 while cnt<ceil(N/2).
//     o_period_tick=1 when cnt==0.
//  Boundary (RUN, cnt==N-1):
//   - pend_vld: apply pend_ratio and pulse o_ratio_ack next cycle.
//   - Then, if !en_q or r_act_new<2: go to BYP; else restart cnt=0 with the new N.
//   - i_ratio_load in the boundary cycle: i_div_ratio is applied directly at that boundary.
//  Disable mid-period: en_q=0 is honoured only at the boundary; the current period completes.
//  Duty:
//   - neg_q <= pos_q on negedge i_ref_clk.
//   - Odd N with DUTY50_ODD=1: div = pos_q & neg_q, high for N/2 ref periods.
//   - Even N, or DUTY50_ODD=0: div = pos_q.
//  Glitch-free mux:
//   - sel_q <= (state!=BYP) on negedge i_ref_clk. o_div_clk = sel_q ? div : i_ref_clk.
//   - sel_q switches only while i_ref_clk is low and div is low.
//   - First divided rising edge is the posedge after ARM.
//  Latency: load in BYP -> ack next cycle -> ARM -> first o_div_clk rise 2 ref cycles after load.
//  o_bypass = !sel_q.
//  Reset mid-operation: all state clears asynchronously; o_div_clk reverts to i_ref_clk.
// STRUCTURE
//  Shared package (clk_div_pkg):
//   - State encoding: BYP=2'd0, ARM=2'd1, RUN=2'd2.
//   - MIN_RATIO=2.
//  Sub-module clk_mux_gf:
//   - Negedge sel flop plus output mux.
//   - Reused by the later clock-switch block.
//  Main module: counter, pending register, FSM, negedge duty stage.
// TESTING
//  1. Reset; no load -> o_div_clk==i_ref_clk, o_bypass=1, ack=0, tick=0.
//  2. en=1, load N=4 -> ack after 1 cycle; o_div_clk 2 high/2 low; tick every 4 cycles.
//  3. N=5, DUTY50_ODD=1 -> high 2.5, low 2.5 ref periods; DUTY50_ODD=0 -> 3/2.
//  4. Running N=4, load N=6 at cnt=1 -> current period stays 4; ack on its boundary;
//     next period is 6; no pulse shorter than 2 ref cycles.
//  5. Running N=3, drop en at cnt=0 -> period completes; bypass from the next negedge;
//     no glitch (high/low widths >= half ref period).
//  6. Load N=1, then N=0, while running -> bypass at the boundary; assert reset mid-period
//     -> immediate bypass, all flags 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared encodings for the runtime-programmable clock divider.
// Divider state codes and the smallest ratio that actually divides.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_BYP = 2'd0,
        ST_ARM = 2'd1,
        ST_RUN = 2'd2
    } state_t;

    localparam int MIN_RATIO = 2;

endpackage

// File: rtl/clk_mux_gf.sv
// Glitch-free select between the reference clock and a divided clock.
// The select flop updates on the falling ref edge, so a switch can only occur while ref is low and div is low.
module clk_mux_gf (
    input  logic ref_clk_i,
    input  logic rst_i,
    input  logic sel_i,
    input  logic div_i,
    output logic clk_o,
    output logic bypass_o
);

    logic sel_q;

    always_ff @(negedge ref_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= sel_i;
        end
    end

    assign clk_o    = sel_q ? div_i : ref_clk_i;
    assign bypass_o = !sel_q;

endmodule

// File: rtl/clk_div_gf.sv
// Integer clock divider; new ratios take effect only at period boundaries, so no runt pulses.
// First divided edge comes 2 ref cycles after a load in bypass; ack and tick are 1-cycle registered pulses.
module clk_div_gf
    import clk_div_pkg::*;
#(
    parameter int DIV_WIDTH  = 8,
    parameter bit DUTY50_ODD = 1'b1
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    input  logic                 i_clk_en,
    input  logic [DIV_WIDTH-1:0] i_div_ratio,
    input  logic                 i_ratio_load,
    output logic                 o_div_clk,
    output logic                 o_ratio_ack,
    output logic                 o_period_tick,
    output logic                 o_bypass
);

    localparam logic [DIV_WIDTH-1:0] MIN_R = DIV_WIDTH'(MIN_RATIO);

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] r_act_q, r_act_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 en_q;
    logic                 ack_q, ack_d;
    logic                 tick_q, tick_d;
    logic                 pos_q, pos_d;
    logic                 neg_q;
    logic                 boundary;
    logic [DIV_WIDTH-1:0] r_new;
    logic [DIV_WIDTH-1:0] half_d;
    logic                 div;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_act_d    = r_act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;

        boundary = (state_q == ST_RUN) && (cnt_q == r_act_q - 1'b1);
        // A load landing exactly on the boundary bypasses the pending register.
        r_new = (boundary && i_ratio_load) ? i_div_ratio :
                (pend_vld_q ? pend_q : r_act_q);

        if (i_ratio_load) begin
            pend_d     = i_div_ratio;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            ST_BYP: begin
                cnt_d = '0;
                if (pend_vld_q) begin
                    r_act_d    = pend_q;
                    ack_d      = 1'b1;
                    pend_vld_d = i_ratio_load;
                end
                if (en_q && (r_new >= MIN_R)) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (pend_vld_q || i_ratio_load) begin
                        r_act_d    = r_new;
                        ack_d      = 1'b1;
                        pend_vld_d = 1'b0;
                    end
                    if (!en_q || (r_new < MIN_R)) begin
                        state_d = ST_BYP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_BYP;
            end
        endcase

        half_d = (r_act_d >> 1) + DIV_WIDTH'(r_act_d[0]);
        pos_d  = (state_d == ST_RUN) && (cnt_d < half_d);
        tick_d = (state_d == ST_RUN) && (cnt_d == '0);
    end

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_BYP;
            cnt_q      <= '0;
            r_act_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            en_q       <= 1'b0;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
            pos_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_act_q    <= r_act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            en_q       <= i_clk_en;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
            pos_q      <= pos_d;
        end
    end

    // Half-cycle delayed copy trims the high phase of odd ratios to exactly N/2.
    always_ff @(negedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign div = (DUTY50_ODD && r_act_q[0]) ? (pos_q & neg_q) : pos_q;

    clk_mux_gf u_mux (
        .ref_clk_i (i_ref_clk),
        .rst_i     (i_rst),
        .sel_i     (state_q != ST_BYP),
        .div_i     (div),
        .clk_o     (o_div_clk),
        .bypass_o  (o_bypass)
    );

    assign o_ratio_ack   = ack_q;
    assign o_period_tick = tick_q;

endmodule
